// File: rtl/spigpio_master.sv
// SPI master for the shift-register GPIO expander: one MSB-first byte per frame, then latch pulses with cs high.
// Frame: done at cycle CLK_DIV*(17+2*LATCH_PULSES)+1, start ignored while busy; SPIGPIO_MASTER_RX_EN adds miso capture.
module spigpio_master #(
  parameter int CLK_DIV      = 4,
  parameter int LATCH_PULSES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       spi_clk,
  output logic       spi_cs,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [3:0] LAT_LAST = (LATCH_PULSES > 0) ? 4'(LATCH_PULSES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, LATCH} state_t;

  state_t        state_q;
  logic [DW-1:0] div_q;
  logic [2:0]    bit_q;
  logic [3:0]    lat_q;
  logic          hi_q;
  logic [6:0]    tx_q;
  logic          busy_q, done_q, clk_q, cs_q, mosi_q;

  logic div_end, frame_end;
  assign div_end   = (div_q == DIV_LAST);
  // Last cycle before returning to IDLE: end of HOLD without latch pulses, or end of the last latch high phase.
  assign frame_end = ((state_q == HOLD) && div_end && (LATCH_PULSES == 0)) ||
                     ((state_q == LATCH) && hi_q && div_end && (lat_q == LAT_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      lat_q   <= '0;
      hi_q    <= 1'b0;
      tx_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clk_q   <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      div_q  <= ((state_q == IDLE) || div_end) ? '0 : div_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (start) begin
            tx_q    <= tx_data[6:0];
            mosi_q  <= tx_data[7];
            cs_q    <= 1'b0;
            clk_q   <= 1'b0;
            busy_q  <= 1'b1;
            hi_q    <= 1'b0;
            bit_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (div_end) begin
            hi_q  <= ~hi_q;
            clk_q <= ~hi_q;
            if (hi_q) begin
              if (bit_q == 3'd7) begin
                state_q <= HOLD;
              end else begin
                mosi_q <= tx_q[6];
                tx_q   <= {tx_q[5:0], 1'b0};
              end
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (div_end) begin
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            lat_q   <= '0;
            hi_q    <= 1'b0;
            state_q <= (LATCH_PULSES == 0) ? IDLE : LATCH;
          end
        end
        LATCH: begin
          if (div_end) begin
            hi_q  <= ~hi_q;
            clk_q <= ~hi_q;
            if (hi_q) lat_q <= lat_q + 1'b1;
            if (frame_end) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (frame_end) begin
        done_q <= 1'b1;
        busy_q <= 1'b0;
      end
    end
  end

`ifdef SPIGPIO_MASTER_RX_EN
  logic [7:0] rx_sr_q, rx_q;

  // miso is sampled on each spi_clk high->low transition, MSB of the expander first.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sr_q <= '0;
      rx_q    <= '0;
    end else begin
      if ((state_q == SHIFT) && hi_q && div_end) rx_sr_q <= {rx_sr_q[6:0], spi_miso};
      if (frame_end) rx_q <= rx_sr_q;
    end
  end
  assign rx_data = rx_q;
`else
  logic unused_miso;
  assign unused_miso = spi_miso;
  assign rx_data     = 8'h00;
`endif

  assign busy     = busy_q;
  assign done     = done_q;
  assign spi_clk  = clk_q;
  assign spi_cs   = cs_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spigpio_master.sv
// Bench for spigpio_master: three instances (D=2/P=1 with expander model, D=1/P=2, D=3/P=0) and a done-driven scoreboard.
`timescale 1ns/1ps
module tb_spigpio_master;

`ifdef SPIGPIO_MASTER_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  localparam int DONE_AT [3] = '{39, 22, 52};
  localparam int PV [3]      = '{1, 2, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst, start;
  logic [7:0] txd [3];
  wire  [2:0] busy, done, sclk, cs, mosi, miso;
  wire  [7:0] rxd [3];

  spigpio_master #(.CLK_DIV(2), .LATCH_PULSES(1)) u0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .tx_data(txd[0]), .busy(busy[0]), .done(done[0]),
    .rx_data(rxd[0]), .spi_clk(sclk[0]), .spi_cs(cs[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0]));
  spigpio_master #(.CLK_DIV(1), .LATCH_PULSES(2)) u1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .tx_data(txd[1]), .busy(busy[1]), .done(done[1]),
    .rx_data(rxd[1]), .spi_clk(sclk[1]), .spi_cs(cs[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1]));
  spigpio_master #(.CLK_DIV(3), .LATCH_PULSES(0)) u2 (
    .clk(clk), .rst(rst[2]), .start(start[2]), .tx_data(txd[2]), .busy(busy[2]), .done(done[2]),
    .rx_data(rxd[2]), .spi_clk(sclk[2]), .spi_cs(cs[2]), .spi_mosi(mosi[2]), .spi_miso(miso[2]));

  // Expander on u0: shifts on rising clk while cs low, presents old sr[7]; latches (pin order reversed) while cs high.
  logic [7:0] ex_sr   = 8'h00;
  logic [7:0] ex_gpio = 8'h00;
  logic       ex_miso = 1'b0;
  always @(posedge sclk[0]) begin
    if (!cs[0]) begin
      ex_sr   <= {ex_sr[6:0], mosi[0]};
      ex_miso <= ex_sr[7];
    end else begin
      for (int b = 0; b < 8; b++) ex_gpio[b] <= ex_sr[7-b];
    end
  end
  assign miso[0] = ex_miso;
  assign miso[1] = 1'b0;
  assign miso[2] = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] rxexp(input logic [7:0] v);
    return RX_EN ? v : 8'h00;
  endfunction

  typedef struct {
    int         inst;
    logic [7:0] tx;
    logic [7:0] rx;
    logic [7:0] gpio;
  } exp_t;
  exp_t sbq [$];

  int         cyc [3], cnt_lo [3], cnt_hi [3], ndone [3];
  logic [7:0] cap [3];
  logic [2:0] prev_sclk = '0, active = '0;

  initial begin
    for (int i = 0; i < 3; i++) begin
      cyc[i] = 0; cnt_lo[i] = 0; cnt_hi[i] = 0; ndone[i] = 0; cap[i] = '0;
    end
  end

  // Monitor: tracks spi_clk edges and cycle count per instance, checks each done against the scoreboard.
  always @(negedge clk) begin : mon
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) begin
        cnt_lo[i] = 0; cnt_hi[i] = 0; cap[i] = '0; active[i] = 1'b0; prev_sclk[i] = 1'b0; cyc[i] = 0;
      end else begin
        if (sclk[i] && !prev_sclk[i]) begin
          if (!cs[i]) begin
            cnt_lo[i]++;
            cap[i] = {cap[i][6:0], mosi[i]};
          end else begin
            cnt_hi[i]++;
          end
        end
        prev_sclk[i] = sclk[i];
        if (active[i]) cyc[i]++;
        if (done[i]) begin
          ndone[i]++;
          if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: inst %0d produced done with nothing expected", i);
          end else begin
            e = sbq.pop_front();
            chk("done_inst", i, e.inst);
            chk("done_cycle", cyc[i], DONE_AT[i]);
            chk("mosi_byte", cap[i], e.tx);
            chk("cs_low_edges", cnt_lo[i], 8);
            chk("latch_edges", cnt_hi[i], PV[i]);
            chk("busy_at_done", busy[i], 0);
            chk("rx_data", rxd[i], e.rx);
            if (i == 0) chk("gpioout", ex_gpio, e.gpio);
          end
          cnt_lo[i] = 0; cnt_hi[i] = 0; cap[i] = '0; active[i] = 1'b0;
        end
        if (start[i] && !busy[i]) begin
          active[i] = 1'b1;
          cyc[i]    = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int i);
    int n = 0;
    while (!done[i] && n < 500) begin
      tick();
      n++;
    end
    if (!done[i]) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: inst %0d never raised done", i);
    end
  endtask

  task automatic send(input int i, input logic [7:0] tx, input logic [7:0] rx, input logic [7:0] gpio);
    sbq.push_back('{i, tx, rx, gpio});
    txd[i]   = tx;
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
    chk("first_busy", busy[i], 1);
    chk("first_cs", cs[i], 0);
    chk("first_mosi", mosi[i], tx[7]);
    chk("first_sclk", sclk[i], 0);
  endtask

  initial begin
    int n;
    rst   = '1;
    start = '0;
    for (int i = 0; i < 3; i++) txd[i] = '0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      chk("rst_cs", cs[i], 1);
      chk("rst_sclk", sclk[i], 0);
      chk("rst_mosi", mosi[i], 0);
      chk("rst_busy", busy[i], 0);
      chk("rst_done", done[i], 0);
      chk("rst_rx", rxd[i], 0);
    end
    rst = '0;
    tick();

    // 0xAA into an empty expander: pins show the reversed byte.
    send(0, 8'hAA, rxexp(8'h00), 8'h55);
    wait_done(0);
    repeat (3) tick();

    // Back-to-back 0xFF then 0xFE with start held high.
    sbq.push_back('{0, 8'hFF, rxexp(8'hAA), 8'hFF});
    sbq.push_back('{0, 8'hFE, rxexp(8'hFF), 8'h7F});
    txd[0]   = 8'hFF;
    start[0] = 1'b1;
    tick();
    txd[0] = 8'hFE;
    wait_done(0);
    tick();
    chk("b2b_busy", busy[0], 1);
    chk("b2b_cs", cs[0], 0);
    chk("b2b_mosi", mosi[0], 1);
    start[0] = 1'b0;
    wait_done(0);
    repeat (3) tick();

    // Abort 0x81 after its third rising edge; the expander keeps 0xF4.
    txd[0]   = 8'h81;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    n = 0;
    while (cnt_lo[0] < 3 && n < 200) begin
      tick();
      n++;
    end
    chk("abort_edges_seen", cnt_lo[0], 3);
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    chk("abort_cs", cs[0], 1);
    chk("abort_sclk", sclk[0], 0);
    chk("abort_busy", busy[0], 0);
    chk("abort_rx", rxd[0], 0);
    tick();
    send(0, 8'h3C, rxexp(8'hF4), 8'h3C);
    wait_done(0);
    repeat (3) tick();

    // D=1, P=2: start pulses at cycles 5 and 20 of the frame are ignored.
    sbq.push_back('{1, 8'h5A, 8'h00, 8'h00});
    txd[1]   = 8'h5A;
    start[1] = 1'b1;
    tick();
    for (int c = 1; c <= 21; c++) begin
      start[1] = (c == 5) || (c == 20);
      tick();
    end
    start[1] = 1'b0;
    repeat (40) tick();

    // D=3, P=0 with miso tied high.
    send(2, 8'hC3, rxexp(8'hFF), 8'h00);
    wait_done(2);
    repeat (5) tick();

    chk("done_count_u0", ndone[0], 4);
    chk("done_count_u1", ndone[1], 1);
    chk("done_count_u2", ndone[2], 1);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
